// File: rtl/led_event_scheduler.sv
// led_event_scheduler
//   Shares one physical LED between a free-running heartbeat (low priority)
//   and an event report (high priority). The 12-bit comparator result is
//   synchronized and debounced; every debounced change adds its changed bits
//   to a pending mask, and the FSM reports the mask as a burst of flashes
//   whose count is the number of set bits.
//
// Ports
//   clk        in   clock
//   rst_n      in   asynchronous active-low reset
//   y_in       in   [11:0] comparator result, asynchronous to clk
//   hb_led     in   heartbeat, active-high, synchronous to clk
//   led        out  physical LED (registered, polarity set by ACTIVE_LOW_LED)
//   y_stable   out  [11:0] last debounced comparator value
//   busy       out  high while a report is running (state != IDLE)
//   flash_cnt  out  [3:0] flashes remaining in the current burst
//   fsm_state  out  [1:0] FSM state for observation (0 IDLE,1 ON,2 OFF,3 GAP)
//
// Handshake: none; hb_led is sampled every cycle, y_in is free-running.
module led_event_scheduler #(
   parameter int F_CLK_HZ       = 25_000_000,
   parameter int DEBOUNCE_MS    = 10,
   parameter int FLASH_ON_MS    = 100,
   parameter int FLASH_OFF_MS   = 150,
   parameter int GAP_MS         = 500,
   parameter bit ACTIVE_LOW_LED = 1'b0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [11:0] y_in,
   input  logic        hb_led,
   output logic        led,
   output logic [11:0] y_stable,
   output logic        busy,
   output logic [3:0]  flash_cnt,
   output logic [1:0]  fsm_state
);

   localparam int MS      = F_CLK_HZ / 1000;
   localparam int DB_CYC  = DEBOUNCE_MS * MS;
   localparam int ON_CYC  = FLASH_ON_MS * MS;
   localparam int OFF_CYC = FLASH_OFF_MS * MS;
   localparam int GAP_CYC = GAP_MS * MS;

   if (DB_CYC < 1 || ON_CYC < 1 || OFF_CYC < 1 || GAP_CYC < 1) begin : g_param_err
      $error("led_event_scheduler: every derived cycle count must be >= 1");
   end

   localparam int T_MAX_A = (ON_CYC > OFF_CYC) ? ON_CYC : OFF_CYC;
   localparam int T_MAX   = (T_MAX_A > GAP_CYC) ? T_MAX_A : GAP_CYC;
   localparam int T_W     = (T_MAX > 1) ? $clog2(T_MAX) : 1;
   localparam int DB_W    = (DB_CYC > 1) ? $clog2(DB_CYC) : 1;

   localparam logic [DB_W-1:0] DB_LAST  = DB_W'(DB_CYC - 1);
   localparam logic [T_W-1:0]  ON_LAST  = T_W'(ON_CYC - 1);
   localparam logic [T_W-1:0]  OFF_LAST = T_W'(OFF_CYC - 1);
   localparam logic [T_W-1:0]  GAP_LAST = T_W'(GAP_CYC - 1);

   typedef enum logic [1:0] {IDLE = 2'd0, ON = 2'd1, OFF = 2'd2, GAP = 2'd3} state_t;

   state_t            state;
   logic [11:0]       s1, s2, cand, pend_mask;
   logic [DB_W-1:0]   db_cnt;
   logic [T_W-1:0]    timer;
   logic              db_fire, take, led_raw;
   logic [11:0]       db_diff;

   function automatic logic [3:0] popcount12(input logic [11:0] v);
      logic [3:0] c;
      c = 4'd0;
      for (int i = 0; i < 12; i++) c = c + {3'd0, v[i]};
      return c;
   endfunction

   // A debounced update fires when the candidate has been steady for the
   // full window and differs from the published value.
   assign db_fire = (s2 == cand) && (db_cnt == DB_LAST) && (cand != y_stable);
   assign db_diff = db_fire ? (cand ^ y_stable) : 12'd0;
   assign take    = (state == IDLE) && (pend_mask != 12'd0);

   // Synchronizer and debouncer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1       <= '0;
         s2       <= '0;
         cand     <= '0;
         db_cnt   <= '0;
         y_stable <= '0;
      end else begin
         s1 <= y_in;
         s2 <= s1;
         if (s2 != cand) begin
            cand   <= s2;
            db_cnt <= '0;
         end else if (db_fire) begin
            y_stable <= cand;
         end else if (db_cnt != DB_LAST) begin
            db_cnt <= db_cnt + 1'b1;
         end
      end
   end

   // Bits arriving in the same cycle the FSM consumes the mask survive.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pend_mask <= '0;
      else        pend_mask <= (take ? 12'd0 : pend_mask) | db_diff;
   end

   always_comb begin
      led_raw = 1'b0;
      case (state)
         IDLE:    led_raw = hb_led;
         ON:      led_raw = 1'b1;
         default: led_raw = 1'b0;
      endcase
   end

   // Report FSM with registered LED output
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         timer     <= '0;
         flash_cnt <= '0;
         led       <= ACTIVE_LOW_LED;
      end else begin
         led <= led_raw ^ ACTIVE_LOW_LED;
         case (state)
            IDLE: begin
               if (take) begin
                  flash_cnt <= popcount12(pend_mask);
                  timer     <= '0;
                  state     <= ON;
               end
            end
            ON: begin
               if (timer == ON_LAST) begin
                  timer     <= '0;
                  flash_cnt <= flash_cnt - 1'b1;
                  state     <= OFF;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            OFF: begin
               if (timer == OFF_LAST) begin
                  timer <= '0;
                  state <= (flash_cnt != 4'd0) ? ON : GAP;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            GAP: begin
               if (timer == GAP_LAST) begin
                  timer <= '0;
                  state <= IDLE;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign busy      = (state != IDLE);
   assign fsm_state = state;

endmodule
